// File: rtl/pll_dco.sv
// Digitally controlled oscillator: divides ClockIn into PLLClock, slewing the divisor from the comparator code.
// Optional macro PLL_DCO_ACCEL_EN enables an accelerating step size for repeated same-direction adjustments.
module pll_dco #(
    parameter int CNT_W    = 8,
    parameter int DIV_INIT = 32,
    parameter int DIV_MIN  = 4,
    parameter int DIV_MAX  = 250,
    parameter int STEP     = 1,
    parameter int SETTLE   = 4,
    parameter int LOCK_CNT = 8
) (
    input  logic             ClockIn,
    input  logic             Reset,
    input  logic [1:0]       AdjustFreq,
    output logic             PLLClock,
    output logic [CNT_W-1:0] Divisor,
    output logic             Locked,
    output logic             AtLimit
);

    localparam int WIDE  = CNT_W + 1;
    localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int LCK_W = $clog2(LOCK_CNT + 1);

    typedef enum logic {
        StRun,
        StSettle
    } state_t;

    state_t           state, stateNext;
    logic [1:0]       syncFf1, syncFf2, syncAdj;
    logic [CNT_W-1:0] perCnt, perNext, divNext;
    logic [SET_W-1:0] settleCnt, settleNext;
    logic [LCK_W-1:0] lockCnt, lockNext;
    logic             lockedNext, clkNext, periodEnd;
    logic [WIDE-1:0]  wideDiv, stepSize, upVal, downVal, target;

`ifdef PLL_DCO_ACCEL_EN
    logic [1:0] accelK, accelKNext;
    logic       lastDir, lastDirNext, dirValid, dirValidNext;
    logic       reversal;
`endif

    assign syncAdj   = syncFf2;
    assign periodEnd = (perCnt == Divisor - CNT_W'(1));
    assign AtLimit   = (Divisor == CNT_W'(DIV_MIN)) || (Divisor == CNT_W'(DIV_MAX));

    always_comb begin
        stateNext  = state;
        settleNext = settleCnt;
        lockNext   = lockCnt;
        lockedNext = Locked;
        divNext    = Divisor;
        perNext    = periodEnd ? '0 : perCnt + CNT_W'(1);
        wideDiv    = {1'b0, Divisor};
`ifdef PLL_DCO_ACCEL_EN
        accelKNext   = accelK;
        lastDirNext  = lastDir;
        dirValidNext = dirValid;
        reversal     = dirValid && (lastDir != (syncAdj == 2'b11));
        stepSize     = WIDE'(STEP) << (reversal ? 2'd0 : accelK);
`else
        stepSize     = WIDE'(STEP);
`endif
        // Both candidates are formed one bit wider so neither direction can wrap before clamping.
        upVal   = wideDiv + stepSize;
        if (upVal > WIDE'(DIV_MAX))
            upVal = WIDE'(DIV_MAX);
        downVal = (wideDiv < WIDE'(DIV_MIN) + stepSize) ? WIDE'(DIV_MIN) : wideDiv - stepSize;
        case (syncAdj)
            2'b11:   target = downVal;
            2'b00:   target = upVal;
            default: target = wideDiv;
        endcase

        if (periodEnd) begin
            case (state)
                StRun: begin
                    if (syncAdj == 2'b01) begin
                        if (lockCnt != LCK_W'(LOCK_CNT))
                            lockNext = lockCnt + LCK_W'(1);
                        lockedNext = (lockNext == LCK_W'(LOCK_CNT));
`ifdef PLL_DCO_ACCEL_EN
                        accelKNext   = 2'd0;
                        dirValidNext = 1'b0;
`endif
                    end else begin
                        lockNext   = '0;
                        lockedNext = 1'b0;
                        if (target != wideDiv) begin
                            divNext = target[CNT_W-1:0];
                            if (SETTLE > 0) begin
                                stateNext  = StSettle;
                                settleNext = SET_W'(SETTLE);
                            end
`ifdef PLL_DCO_ACCEL_EN
                            accelKNext   = reversal ? 2'd0 : ((accelK == 2'd3) ? 2'd3 : accelK + 2'd1);
                            lastDirNext  = (syncAdj == 2'b11);
                            dirValidNext = 1'b1;
`endif
                        end else begin
`ifdef PLL_DCO_ACCEL_EN
                            accelKNext   = 2'd0;
                            dirValidNext = 1'b0;
`endif
                        end
                    end
                end
                StSettle: begin
                    if (settleCnt <= SET_W'(1)) begin
                        settleNext = '0;
                        stateNext  = StRun;
                    end else begin
                        settleNext = settleCnt - SET_W'(1);
                    end
                end
                default: stateNext = StRun;
            endcase
        end

        // The new divisor already governs the half-period split of the period that starts here.
        clkNext = (perNext < (divNext >> 1));
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            syncFf1   <= 2'b01;
            syncFf2   <= 2'b01;
            perCnt    <= '0;
            state     <= StRun;
            settleCnt <= '0;
            lockCnt   <= '0;
            Locked    <= 1'b0;
            Divisor   <= CNT_W'(DIV_INIT);
            PLLClock  <= 1'b0;
        end else begin
            syncFf1   <= AdjustFreq;
            syncFf2   <= syncFf1;
            perCnt    <= perNext;
            state     <= stateNext;
            settleCnt <= settleNext;
            lockCnt   <= lockNext;
            Locked    <= lockedNext;
            Divisor   <= divNext;
            PLLClock  <= clkNext;
        end
    end

`ifdef PLL_DCO_ACCEL_EN
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            accelK   <= 2'd0;
            lastDir  <= 1'b0;
            dirValid <= 1'b0;
        end else begin
            accelK   <= accelKNext;
            lastDir  <= lastDirNext;
            dirValid <= dirValidNext;
        end
    end
`endif

endmodule

// File: tb/tb_pll_dco.sv
// Self-checking bench for pll_dco: directed scenarios plus random code segments against a reference model.
module tb_pll_dco;

    localparam int CNT_W    = 8;
    localparam int DIV_INIT = 32;
    localparam int DIV_MIN  = 4;
    localparam int DIV_MAX  = 250;
    localparam int STEP     = 1;
    localparam int SETTLE   = 4;
    localparam int LOCK_CNT = 8;

    logic             ClockIn = 1'b0;
    logic             Reset = 1'b1;
    logic [1:0]       AdjustFreq = 2'b01;
    logic             PLLClock;
    logic [CNT_W-1:0] Divisor;
    logic             Locked;
    logic             AtLimit;

    int errors = 0;
    int checks = 0;

    // Reference model: position inside the current period, divisor, skipped-decision budget, lock run.
    int         mDiv, mPos, mSkip, mRun;
    bit         mLocked, mClk;
    logic [1:0] mPipe[$];

    pll_dco #(
        .CNT_W(CNT_W), .DIV_INIT(DIV_INIT), .DIV_MIN(DIV_MIN), .DIV_MAX(DIV_MAX),
        .STEP(STEP), .SETTLE(SETTLE), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .ClockIn(ClockIn),
        .Reset(Reset),
        .AdjustFreq(AdjustFreq),
        .PLLClock(PLLClock),
        .Divisor(Divisor),
        .Locked(Locked),
        .AtLimit(AtLimit)
    );

    always #5 ClockIn = ~ClockIn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeoutFail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    function automatic void modelReset();
        mDiv = DIV_INIT; mPos = 0; mSkip = 0; mRun = 0; mLocked = 0; mClk = 0;
        mPipe = '{2'b01, 2'b01};
    endfunction

    function automatic void modelEdge(input logic [1:0] code);
        logic [1:0] used;
        int tgt;
        used = mPipe.pop_front();
        mPipe.push_back(code);
        if (mPos == mDiv - 1) begin
            mPos = 0;
            if (mSkip > 0) begin
                mSkip--;
            end else if (used == 2'b01) begin
                if (mRun < LOCK_CNT) mRun++;
                if (mRun == LOCK_CNT) mLocked = 1;
            end else begin
                mRun = 0;
                mLocked = 0;
                tgt = mDiv;
                if (used == 2'b11) tgt = (mDiv - STEP < DIV_MIN) ? DIV_MIN : mDiv - STEP;
                if (used == 2'b00) tgt = (mDiv + STEP > DIV_MAX) ? DIV_MAX : mDiv + STEP;
                if (tgt != mDiv) begin
                    mDiv = tgt;
                    mSkip = SETTLE;
                end
            end
        end else begin
            mPos++;
        end
        mClk = (mPos < mDiv / 2);
    endfunction

    task automatic tick();
        logic [1:0] code;
        code = AdjustFreq;
        @(posedge ClockIn);
        if (Reset) modelReset();
        else modelEdge(code);
        @(negedge ClockIn);
        check("PLLClock", 32'(PLLClock), 32'(mClk));
        check("Divisor", 32'(Divisor), mDiv);
        check("Locked", 32'(Locked), 32'(mLocked));
        check("AtLimit", 32'(AtLimit), 32'(mDiv == DIV_MIN || mDiv == DIV_MAX));
    endtask

    task automatic doReset(input logic [1:0] code);
        Reset = 1'b1;
        AdjustFreq = code;
        repeat (2) tick();
        Reset = 1'b0;
        check("reset_PLLClock", 32'(PLLClock), 0);
        check("reset_Divisor", 32'(Divisor), DIV_INIT);
        check("reset_Locked", 32'(Locked), 0);
        check("reset_AtLimit", 32'(AtLimit), 0);
    endtask

    task automatic runUntilDiv(input logic [1:0] code, input int target, input int limit, input string tag);
        int n;
        AdjustFreq = code;
        n = 0;
        while (mDiv != target && n < limit) begin
            tick();
            n++;
        end
        if (mDiv != target) timeoutFail(tag);
    endtask

    task automatic measureDuty(input string tag, input int expHigh, input int expLow);
        int n, hi, lo;
        n = 0;
        while (PLLClock !== 1'b0 && n < 300) begin tick(); n++; end
        n = 0;
        while (PLLClock !== 1'b1 && n < 300) begin tick(); n++; end
        if (PLLClock !== 1'b1) begin
            timeoutFail(tag);
            return;
        end
        hi = 0;
        while (PLLClock === 1'b1 && hi < 300) begin hi++; tick(); end
        lo = 0;
        while (PLLClock === 1'b0 && lo < 300) begin lo++; tick(); end
        check({tag, "_high"}, hi, expHigh);
        check({tag, "_low"}, lo, expLow);
    endtask

    initial begin
        int n, len, r;
        modelReset();

        // Steady 01 from reset: lock at the 8th period end, 16/16 duty.
        doReset(2'b01);
        repeat (255) tick();
        check("lock_before_8th", 32'(Locked), 0);
        tick();
        check("lock_at_8th", 32'(Locked), 1);
        check("lock_div", 32'(Divisor), 32);
        measureDuty("duty32", 16, 16);

        // Held 11: changes at period ends 1, 6 and 11 of the slewing sequence.
        doReset(2'b11);
        repeat (31) tick();
        check("slew_pre1", 32'(Divisor), 32);
        tick();
        check("slew_1st", 32'(Divisor), 31);
        repeat (154) tick();
        check("slew_pre6", 32'(Divisor), 31);
        tick();
        check("slew_6th", 32'(Divisor), 30);
        check("slew_locked", 32'(Locked), 0);
        runUntilDiv(2'b11, DIV_MIN, 6000, "reach_min");
        repeat (100) tick();
        check("min_div", 32'(Divisor), DIV_MIN);
        check("min_atlimit", 32'(AtLimit), 1);
        check("min_locked", 32'(Locked), 0);
        measureDuty("duty4", 2, 2);

        // Back up to an odd divisor, lock, then an invalid code.
        runUntilDiv(2'b00, 31, 6000, "reach_31");
        AdjustFreq = 2'b01;
        repeat (12 * 31) tick();
        check("odd_locked", 32'(Locked), 1);
        measureDuty("duty31", 15, 16);
        AdjustFreq = 2'b10;
        n = 0;
        while (Locked === 1'b1 && n < 100) begin tick(); n++; end
        if (Locked === 1'b1) timeoutFail("invalid_unlock");
        check("invalid_div", 32'(Divisor), 31);

        // Random code segments of random length.
        for (int s = 0; s < 25; s++) begin
            r = $urandom_range(0, 9);
            AdjustFreq = (r < 3) ? 2'b11 : (r < 6) ? 2'b00 : (r < 9) ? 2'b01 : 2'b10;
            len = $urandom_range(1, 150);
            repeat (len) tick();
        end

        // Asynchronous reset while settling at Divisor=20.
        doReset(2'b11);
        runUntilDiv(2'b11, 20, 4000, "reach_20");
        repeat (3) tick();
        check("mid_in_settle", 32'(mSkip > 0), 1);
        #2 Reset = 1'b1;
        #1;
        check("async_PLLClock", 32'(PLLClock), 0);
        check("async_Divisor", 32'(Divisor), DIV_INIT);
        check("async_Locked", 32'(Locked), 0);
        check("async_AtLimit", 32'(AtLimit), 0);
        modelReset();
        repeat (3) tick();
        Reset = 1'b0;
        AdjustFreq = 2'b01;
        repeat (100) tick();
        check("resume_div", 32'(Divisor), DIV_INIT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
